sp_ram_arbiter: RTL and testbench
=================================

# sp_ram_arbiter

Two-requester round-robin arbiter that shares one single-port RAM (`sp_ram`: `clk`, `en`, `wen`, `addr`, `din`, `q`; `q` registered, one-cycle read latency) between requesters A and B. Each requester issues read or write commands through a valid/ready handshake. Read data returns on a per-requester response strobe exactly one cycle after acceptance. The block sits directly in front of `sp_ram` and is the only master driving its ports. Per-requester saturating grant counters support debug and fairness checks.

## Interface
Parameters:
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 5: RAM address width; depth is 2**ADDR_WIDTH.
- `STAT_WIDTH`, 16: width of each grant counter.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arb_en` in 1: global enable; when low, no grants are issued.
- `a_valid` in 1: requester A command valid.
- `a_ready` out 1: A command accepted this cycle.
- `a_wr` in 1: 1 = write, 0 = read.
- `a_addr` in ADDR_WIDTH: A address.
- `a_wdata` in DATA_WIDTH: A write data.
- `a_rvalid` out 1: A read data valid.
- `a_rdata` out DATA_WIDTH: A read data.
- `b_valid`, `b_ready`, `b_wr`, `b_addr`, `b_wdata`, `b_rvalid`, `b_rdata`: same as the A ports, for requester B.
- `ram_en` out 1, `ram_wen` out 1, `ram_addr` out ADDR_WIDTH, `ram_din` out DATA_WIDTH: drive `sp_ram`.
- `ram_q` in DATA_WIDTH: `sp_ram` read data.
- `a_grant_cnt`, `b_grant_cnt` out STAT_WIDTH: accepted-command counts.

## Operation
- **Grant decision.** Combinational, from `arb_en`, `a_valid`, `b_valid` and the round-robin pointer `last` (1 bit; 0 = A granted last, 1 = B granted last).
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to `last` is granted.
  - `arb_en` = 0: no grant.
- **Ready.** `a_ready`/`b_ready` equal the grant. A command transfers when valid && ready. At most one ready is high per cycle.
- **RAM drive on a grant.**
  - `ram_en` = 1.
  - `ram_wen` = granted `wr`.
  - `ram_addr`/`ram_din` = granted `addr`/`wdata`.
  - With no grant, `ram_en` = `ram_wen` = 0 and `ram_addr` = `ram_din` = 0.
- **Pointer update.** `last` updates to the granted requester on every grant and holds otherwise.
- **Read responses.**
  - A registered tag (`rsp_pend` 1 bit, `rsp_id` 1 bit) is set when a read is accepted.
  - The next cycle: `x_rvalid` = 1 for the tagged requester only, and `x_rdata` = `ram_q`.
  - `x_rdata` is `ram_q` whenever `x_rvalid` = 0 as well; its value is don't-care then.
  - Responses have no backpressure; requesters must take them.
- **Writes.** No response is produced.
- **Back-to-back traffic.** Accepting a new command in the cycle a response is returned is legal, so full throughput is 1 command/cycle.
- **Grant counters.** Each increments by 1 per accepted command (read or write) and saturates at 2**STAT_WIDTH−1.

## Timing
- **Reset values.**
  - `last` = 1, so A wins the first tie.
  - `rsp_pend` = 0; `a_rvalid` = `b_rvalid` = 0.
  - Both grant counters = 0.
  - `ram_en` = `ram_wen` = 0 whenever no valid is asserted.
- **Latency.**
  - Grant/ready: 0 cycles, combinational from valid.
  - Read accepted at edge N: rvalid is high in cycle N+1.
  - Write accepted at edge N: RAM is updated at edge N.
- **Contention.** Under continuous requests from both requesters, grants strictly alternate A, B, A, B…; neither requester waits more than 1 cycle.
- **Read after write.** Write at N followed by a read of the same address at N+1, from either requester, returns the new data at N+2.
- **Disable mid-traffic.** When `arb_en` drops, a response already pending still returns the next cycle, and `last` holds.
- **Reset mid-read.** `rst` asserted in the cycle after a read was accepted forces rvalid to 0 in the following cycle; the response is dropped.
- **Held valid.** A requester whose valid is held while not granted must keep its command stable; the arbiter does not latch commands.

## Test plan
- **Reset.** Hold `rst` 3 cycles with both valids high → readies, rvalids and `ram_en` all 0; counters 0. First cycle after reset grants A.
- **Single requester.** A alone writes addr i = i for i = 0..31, then reads 0..31 → each `a_rvalid` arrives one cycle after acceptance with `a_rdata` = i; `b_rvalid` never asserts; `a_grant_cnt` = 64.
- **Contention.** Both valid for 20 cycles (A writes addr 3 = 0x55; B reads addr 3 continuously) → ready alternates A, B, …; B's read data is 0x55 after A's first write; each counter = 10.
- **Read-after-write across requesters.** B writes 0xAA to addr 7 at cycle N; A reads addr 7 at N+1 → `a_rvalid` at N+2 with 0xAA.
- **Disable and reset mid-operation.**
  - `arb_en` = 0 with A valid → `a_ready` stays 0 and `ram_en` = 0.
  - Read accepted, then `rst` next cycle → no rvalid.
- **Counter saturation.** With `STAT_WIDTH` = 4, issue 20 A commands → `a_grant_cnt` stops at 15.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Grants are combinational. Read data returns one cycle after acceptance.
module sp_ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arb_en,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_en,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [STAT_WIDTH-1:0] a_grant_cnt,
    output logic [STAT_WIDTH-1:0] b_grant_cnt
);

    localparam logic [STAT_WIDTH-1:0] CNT_MAX = '1;

    logic                  grant_a_c;
    logic                  grant_b_c;
    logic                  last_q,     last_d;
    logic                  rsp_pend_q, rsp_pend_d;
    logic                  rsp_id_q,   rsp_id_d;
    logic [STAT_WIDTH-1:0] a_cnt_q,    a_cnt_d;
    logic [STAT_WIDTH-1:0] b_cnt_q,    b_cnt_d;

    // Grant: sole requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (!rst && arb_en) begin
            if (a_valid && (!b_valid || last_q)) begin
                grant_a_c = 1'b1;
            end else if (b_valid) begin
                grant_b_c = 1'b1;
            end
        end
    end

    // RAM port mux; idle cycles drive all-zero.
    always_comb begin
        ram_en   = 1'b0;
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (grant_a_c) begin
            ram_en   = 1'b1;
            ram_wen  = a_wr;
            ram_addr = a_addr;
            ram_din  = a_wdata;
        end else if (grant_b_c) begin
            ram_en   = 1'b1;
            ram_wen  = b_wr;
            ram_addr = b_addr;
            ram_din  = b_wdata;
        end
    end

    always_comb begin
        last_d     = last_q;
        rsp_pend_d = 1'b0;
        rsp_id_d   = rsp_id_q;
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        if (grant_a_c) begin
            last_d     = 1'b0;
            rsp_pend_d = !a_wr;
            rsp_id_d   = 1'b0;
            a_cnt_d    = (a_cnt_q == CNT_MAX) ? a_cnt_q : a_cnt_q + STAT_WIDTH'(1);
        end else if (grant_b_c) begin
            last_d     = 1'b1;
            rsp_pend_d = !b_wr;
            rsp_id_d   = 1'b1;
            b_cnt_d    = (b_cnt_q == CNT_MAX) ? b_cnt_q : b_cnt_q + STAT_WIDTH'(1);
        end
    end

    // last resets to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
        end else begin
            last_q     <= last_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
        end
    end

    // A reset arriving while a response is outstanding drops that response.
    assign a_rvalid    = rsp_pend_q && !rsp_id_q && !rst;
    assign b_rvalid    = rsp_pend_q &&  rsp_id_q && !rst;
    assign a_rdata     = ram_q;
    assign b_rdata     = ram_q;
    assign a_ready     = grant_a_c;
    assign b_ready     = grant_b_c;
    assign a_grant_cnt = a_cnt_q;
    assign b_grant_cnt = b_cnt_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter: a reference model predicts grants and
// read data, and a separate monitor checks responses against queued expectations.
module tb_sp_ram_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned SW = 16;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, arb_en;
    logic          a_valid, a_ready, a_wr, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_wr, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          ram_en, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_q;
    logic [SW-1:0] a_grant_cnt, b_grant_cnt;

    sp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_q(ram_q), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
    );

    // Second instance with narrow counters for the saturation check.
    logic          s_rst, s_a_valid, s_a_ready, s_a_rvalid, s_b_ready, s_b_rvalid;
    logic          s_ram_en, s_ram_wen;
    logic [AW-1:0] s_ram_addr;
    logic [DW-1:0] s_a_rdata, s_b_rdata, s_ram_din;
    logic [DW-1:0] s_ram_q;
    logic [3:0]    s_a_cnt, s_b_cnt;

    sp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STAT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(s_rst), .arb_en(1'b1),
        .a_valid(s_a_valid), .a_ready(s_a_ready), .a_wr(1'b1), .a_addr(5'd0),
        .a_wdata(8'd0), .a_rvalid(s_a_rvalid), .a_rdata(s_a_rdata),
        .b_valid(1'b0), .b_ready(s_b_ready), .b_wr(1'b0), .b_addr(5'd0),
        .b_wdata(8'd0), .b_rvalid(s_b_rvalid), .b_rdata(s_b_rdata),
        .ram_en(s_ram_en), .ram_wen(s_ram_wen), .ram_addr(s_ram_addr), .ram_din(s_ram_din),
        .ram_q(s_ram_q), .a_grant_cnt(s_a_cnt), .b_grant_cnt(s_b_cnt)
    );

    // Behavioural single-port RAM with registered read data.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) ram_mem[ram_addr] <= ram_din;
            else         ram_q <= ram_mem[ram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: memory image, round-robin pointer, counters.
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    bit            m_last = 1'b1;
    int            m_ca = 0, m_cb = 0;
    bit            m_ga, m_gb;
    rsp_t          qa[$], qb[$];

    always @(negedge clk) begin
        rsp_t r;
        m_ga = !rst && arb_en && a_valid && (!b_valid || m_last);
        m_gb = !rst && arb_en && b_valid && (!a_valid || !m_last);
        if (chk_on) begin
            check("a_ready", 32'(a_ready), 32'(m_ga));
            check("b_ready", 32'(b_ready), 32'(m_gb));
            check("ram_en",  32'(ram_en),  32'(m_ga || m_gb));
            check("ram_wen", 32'(ram_wen), m_ga ? 32'(a_wr) : m_gb ? 32'(b_wr) : 32'd0);
            check("ram_addr", 32'(ram_addr), m_ga ? 32'(a_addr) : m_gb ? 32'(b_addr) : 32'd0);
            check("ram_din", 32'(ram_din), m_ga ? 32'(a_wdata) : m_gb ? 32'(b_wdata) : 32'd0);
            check("a_grant_cnt", 32'(a_grant_cnt), 32'(m_ca));
            check("b_grant_cnt", 32'(b_grant_cnt), 32'(m_cb));
        end
        if (rst) begin
            m_last = 1'b1;
            m_ca   = 0;
            m_cb   = 0;
        end else if (m_ga) begin
            m_last = 1'b0;
            if (m_ca < 65535) m_ca++;
            if (a_wr) m_mem[a_addr] = a_wdata;
            else begin r.due = cyc + 1; r.data = m_mem[a_addr]; qa.push_back(r); end
        end else if (m_gb) begin
            m_last = 1'b1;
            if (m_cb < 65535) m_cb++;
            if (b_wr) m_mem[b_addr] = b_wdata;
            else begin r.due = cyc + 1; r.data = m_mem[b_addr]; qb.push_back(r); end
        end
    end

    // Response monitor: pops one expectation per observed strobe.
    always @(negedge clk) begin
        if (chk_on) begin
            if (rst) begin
                check("a_rvalid_in_reset", 32'(a_rvalid), 32'd0);
                check("b_rvalid_in_reset", 32'(b_rvalid), 32'd0);
                while (qa.size() > 0 && qa[0].due <= cyc) void'(qa.pop_front());
                while (qb.size() > 0 && qb[0].due <= cyc) void'(qb.pop_front());
            end else begin
                if (a_rvalid === 1'b1) begin
                    if (qa.size() == 0 || qa[0].due != cyc) begin
                        check("a_rvalid_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("a_rdata", 32'(a_rdata), 32'(qa[0].data));
                        void'(qa.pop_front());
                    end
                end else if (qa.size() > 0 && qa[0].due <= cyc) begin
                    check("a_rvalid_missing", 32'(a_rvalid), 32'd1);
                    void'(qa.pop_front());
                end
                if (b_rvalid === 1'b1) begin
                    if (qb.size() == 0 || qb[0].due != cyc) begin
                        check("b_rvalid_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("b_rdata", 32'(b_rdata), 32'(qb[0].data));
                        void'(qb.pop_front());
                    end
                end else if (qb.size() > 0 && qb[0].due <= cyc) begin
                    check("b_rvalid_missing", 32'(b_rvalid), 32'd1);
                    void'(qb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_valid = av; a_wr = aw; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_wr = bw; b_addr = ba; b_wdata = bd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        s_rst = 1'b1; s_a_valid = 1'b0; s_ram_q = '0;
        rst = 1'b1; arb_en = 1'b1;
        a_valid = 1'b1; a_wr = 1'b1; a_addr = 5'd0; a_wdata = 8'h11;
        b_valid = 1'b1; b_wr = 1'b1; b_addr = 5'd1; b_wdata = 8'h22;

        // Reset held three cycles with both requesters asking.
        @(posedge clk);
        chk_on = 1'b1;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // First post-reset tie goes to A; B keeps its command until served.
        drive(1, 1, 5'd0, 8'h11, 1, 1, 5'd1, 8'h22);
        drive(0, 0, 5'd0, 8'h00, 1, 1, 5'd1, 8'h22);

        // Single requester: fill then read back every address.
        for (int i = 0; i < 32; i++) drive(1, 1, AW'(i), DW'(i), 0, 0, 5'd0, 8'h00);
        for (int i = 0; i < 32; i++) drive(1, 0, AW'(i), 8'h00, 0, 0, 5'd0, 8'h00);
        drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

        // Contention: A writes, B reads the same address.
        for (int i = 0; i < 20; i++) drive(1, 1, 5'd3, 8'h55, 1, 0, 5'd3, 8'h00);
        drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

        // Read-after-write across requesters.
        drive(0, 0, 5'd0, 8'h00, 1, 1, 5'd7, 8'hAA);
        drive(1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00);
        drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

        // Disabled arbiter holds A off; then a read followed by disable still responds.
        arb_en = 1'b0;
        repeat (3) drive(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
        arb_en = 1'b1;
        drive(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
        drive(1, 0, 5'd9, 8'h00, 0, 0, 5'd0, 8'h00);
        arb_en = 1'b0;
        drive(1, 0, 5'd10, 8'h00, 0, 0, 5'd0, 8'h00);
        arb_en = 1'b1;
        drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

        // Reset right after a read is accepted drops the response.
        drive(1, 0, 5'd12, 8'h00, 0, 0, 5'd0, 8'h00);
        rst = 1'b1;
        drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
        rst = 1'b0;
        drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

        // Randomized traffic; an ungranted requester holds its command.
        for (int n = 0; n < 600; n++) begin
            arb_en = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            if (!(a_valid && !m_ga)) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_wr    = 1'($urandom_range(0, 1));
                a_addr  = AW'($urandom);
                a_wdata = DW'($urandom);
            end
            if (!(b_valid && !m_gb)) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_wr    = 1'($urandom_range(0, 1));
                b_addr  = AW'($urandom);
                b_wdata = DW'($urandom);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        repeat (3) drive(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
        check("a_rsp_queue_drained", 32'(qa.size()), 32'd0);
        check("b_rsp_queue_drained", 32'(qb.size()), 32'd0);

        // Counter saturation on the narrow-counter instance.
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        check("sat_cnt_reset", 32'(s_a_cnt), 32'd0);
        s_a_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check("sat_a_grant_cnt", 32'(s_a_cnt), (k > 15) ? 32'd15 : 32'(k));
        end
        s_a_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
